// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 32-bit ALU: one valid/ready command in, one valid/ready response out.
// Optional feature macro ALU_SEQ_PERF_EN adds the ops_done counter and mod_busy status outputs.
module alu_op_sequencer #(
    parameter int          WIDTH       = 32,
    parameter logic [2:0]  MOD_OP      = 3'b111,
    parameter int          MOD_LATENCY = 34
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             mod_clr,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
`ifdef ALU_SEQ_PERF_EN
    output logic [15:0]      ops_done,
    output logic             mod_busy,
`endif
    output logic [2:0]       dbg_state
);

    localparam int CW = $clog2(MOD_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_CLR  = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    state_d  = (cmd_op == MOD_OP) ? S_CLR : S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result;
                state_d      = S_RESP;
            end
            S_CLR: begin
                cnt_d   = CW'(MOD_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter reaching zero marks the last of MOD_LATENCY wait cycles.
                if (cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'b000;
            rsp_result_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign mod_clr    = (state_q == S_CLR);
    assign rsp_valid  = (state_q == S_RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign dbg_state  = state_q;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] ops_done_q, ops_done_d;

    always_comb begin
        ops_done_d = ops_done_q;
        if (rsp_valid && rsp_ready && (ops_done_q != 16'hFFFF))
            ops_done_d = ops_done_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) ops_done_q <= 16'd0;
        else       ops_done_q <= ops_done_d;
    end

    assign ops_done = ops_done_q;
    assign mod_busy = (state_q == S_CLR) || (state_q == S_WAIT);
`endif

endmodule
